// File: rtl/intr_arbiter.sv
// ============================================================================
// Module   : intr_arbiter
// Brief    : External-interrupt arbiter with request/claim/complete handshake.
//            Optional macro INTR_EDGE_EN selects edge-captured pending bits.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module intr_arbiter #(
    parameter int NUM_SRC    = 8,
    parameter int PRIO_W     = 3,
    parameter int CAUSE_BASE = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic               cfg_wr_i,
    input  logic [4:0]         cfg_addr_i,
    input  logic [15:0]        cfg_wdata_i,
    output logic [15:0]        cfg_rdata_o,
    output logic               m_ext_intr_o,
    output logic [30:0]        mcause_o,
    input  logic               p_int_read_i,
    input  logic               complete_i,
    output logic [3:0]         claim_id_o,
    output logic               busy_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [PRIO_W-1:0]   prio [NUM_SRC];
    logic [NUM_SRC-1:0]  enable;
    logic [PRIO_W-1:0]   threshold;
    logic [NUM_SRC-1:0]  pending;
    logic [3:0]          req_id;
    logic [3:0]          claim_id;
    logic [30:0]         mcause;
    logic [NUM_SRC-1:0]  cand;
    logic                win_valid;
    logic [3:0]          win_id;
    logic [PRIO_W-1:0]   win_prio;
    logic                req_cand;
    logic                take_req;
    logic                do_claim;

    // Upper write-data bits are architecturally don't-care.
    logic unused_wdata;
    assign unused_wdata = &{1'b0, cfg_wdata_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            enable    <= '0;
            threshold <= '0;
            for (int i = 0; i < NUM_SRC; i++) prio[i] <= '0;
        end else if (cfg_wr_i) begin
            if (cfg_addr_i == 5'h10) enable <= cfg_wdata_i[NUM_SRC-1:0];
            if (cfg_addr_i == 5'h11) threshold <= cfg_wdata_i[PRIO_W-1:0];
            for (int i = 0; i < NUM_SRC; i++) begin
                if (cfg_addr_i == 5'(i)) prio[i] <= cfg_wdata_i[PRIO_W-1:0];
            end
        end
    end

    always_comb begin
        cfg_rdata_o = '0;
        if (cfg_addr_i == 5'h10) cfg_rdata_o[NUM_SRC-1:0] = enable;
        if (cfg_addr_i == 5'h11) cfg_rdata_o[PRIO_W-1:0] = threshold;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cfg_addr_i == 5'(i)) cfg_rdata_o[PRIO_W-1:0] = prio[i];
        end
    end

`ifdef INTR_EDGE_EN
    logic [NUM_SRC-1:0] src_prev;
    logic [NUM_SRC-1:0] clr_mask;

    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (do_claim && req_id == 4'(i)) clr_mask[i] = 1'b1;
        end
    end

    // A new rising edge beats the claim-clear of the same bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            src_prev <= '0;
            pending  <= '0;
        end else begin
            src_prev <= src_i;
            pending  <= (pending & ~clr_mask) | (src_i & ~src_prev);
        end
    end
`else
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) pending <= '0;
        else       pending <= src_i;
    end
`endif

    always_comb begin
        cand      = '0;
        win_valid = 1'b0;
        win_id    = '0;
        win_prio  = '0;
        req_cand  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand[i] = pending[i] && enable[i] && (prio[i] > threshold)
                      && !(state == SERVICE && claim_id == 4'(i));
        end
        // Strict '>' keeps the lowest index on equal priority.
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cand[i] && (!win_valid || prio[i] > win_prio)) begin
                win_valid = 1'b1;
                win_id    = 4'(i);
                win_prio  = prio[i];
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (req_id == 4'(i)) req_cand = cand[i];
        end
    end

    always_comb begin
        state_next = state;
        take_req   = 1'b0;
        do_claim   = 1'b0;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    state_next = REQ;
                    take_req   = 1'b1;
                end
            end
            REQ: begin
                if (p_int_read_i) begin
                    state_next = SERVICE;
                    do_claim   = 1'b1;
                end else if (!req_cand) begin
                    state_next = IDLE;
                end
            end
            SERVICE: begin
                if (complete_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            req_id   <= '0;
            claim_id <= '0;
            mcause   <= '0;
        end else begin
            state <= state_next;
            if (take_req) begin
                req_id <= win_id;
                mcause <= 31'(CAUSE_BASE) + 31'(win_id);
            end
            if (do_claim) claim_id <= req_id;
        end
    end

    assign m_ext_intr_o = (state == REQ);
    assign busy_o       = (state != IDLE);
    assign mcause_o     = mcause;
    assign claim_id_o   = claim_id;

endmodule

`default_nettype wire

// File: tb/tb_intr_arbiter.sv
// ============================================================================
// Module   : tb_intr_arbiter
// Brief    : Randomized self-checking bench for intr_arbiter with a
//            behavioural reference model (honours INTR_EDGE_EN).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_intr_arbiter;

    localparam int NS = 8;
    localparam int PW = 3;
    localparam int CB = 16;

    logic          clk_i;
    logic          rst_i;
    logic [NS-1:0] src_i;
    logic          cfg_wr_i;
    logic [4:0]    cfg_addr_i;
    logic [15:0]   cfg_wdata_i;
    logic [15:0]   cfg_rdata_o;
    logic          m_ext_intr_o;
    logic [30:0]   mcause_o;
    logic          p_int_read_i;
    logic          complete_i;
    logic [3:0]    claim_id_o;
    logic          busy_o;

    intr_arbiter #(.NUM_SRC(NS), .PRIO_W(PW), .CAUSE_BASE(CB)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .src_i        (src_i),
        .cfg_wr_i     (cfg_wr_i),
        .cfg_addr_i   (cfg_addr_i),
        .cfg_wdata_i  (cfg_wdata_i),
        .cfg_rdata_o  (cfg_rdata_o),
        .m_ext_intr_o (m_ext_intr_o),
        .mcause_o     (mcause_o),
        .p_int_read_i (p_int_read_i),
        .complete_i   (complete_i),
        .claim_id_o   (claim_id_o),
        .busy_o       (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: architectural state kept as plain variables.
    bit          m_pend [NS];
`ifdef INTR_EDGE_EN
    bit          m_prev [NS];
`endif
    int          m_pri  [NS];
    bit [NS-1:0] m_en;
    int          m_thr;
    bit          posted;
    bit          in_service;
    int          posted_id;
    int          served_id;
    int          cause;

    function automatic void model_reset();
        for (int i = 0; i < NS; i++) begin
            m_pend[i] = 0;
`ifdef INTR_EDGE_EN
            m_prev[i] = 0;
`endif
            m_pri[i]  = 0;
        end
        m_en = '0; m_thr = 0;
        posted = 0; in_service = 0;
        posted_id = 0; served_id = 0; cause = 0;
    endfunction

    function automatic int model_rdata(input logic [4:0] a);
        if (int'(a) < NS) return m_pri[a];
        if (a == 5'h10)   return int'(m_en);
        if (a == 5'h11)   return m_thr;
        return 0;
    endfunction

    function automatic void model_edge();
        bit c [NS];
        int w;
        bit claim_fire;
        bit [NS-1:0] s;
        s = src_i;
        for (int i = 0; i < NS; i++)
            c[i] = m_pend[i] && m_en[i] && (m_pri[i] > m_thr) && !(in_service && served_id == i);
        // Scan priorities from highest down, indices ascending.
        w = -1;
        for (int p = (1 << PW) - 1; p >= 1 && w < 0; p--)
            for (int i = 0; i < NS && w < 0; i++)
                if (c[i] && m_pri[i] == p) w = i;
        claim_fire = 0;
        if (in_service) begin
            if (complete_i) in_service = 0;
        end else if (posted) begin
            if (p_int_read_i) begin
                claim_fire = 1; posted = 0; in_service = 1; served_id = posted_id;
            end else if (!c[posted_id]) begin
                posted = 0;
            end
        end else if (w >= 0) begin
            posted = 1; posted_id = w; cause = CB + w;
        end
        for (int i = 0; i < NS; i++) begin
`ifdef INTR_EDGE_EN
            m_pend[i] = (m_pend[i] && !(claim_fire && posted_id == i)) || (s[i] && !m_prev[i]);
            m_prev[i] = s[i];
`else
            m_pend[i] = s[i];
`endif
        end
        if (cfg_wr_i) begin
            if (int'(cfg_addr_i) < NS) m_pri[cfg_addr_i] = int'(cfg_wdata_i) % (1 << PW);
            if (cfg_addr_i == 5'h10)   m_en  = cfg_wdata_i[NS-1:0];
            if (cfg_addr_i == 5'h11)   m_thr = int'(cfg_wdata_i) % (1 << PW);
        end
    endfunction

    task automatic cyc();
        @(negedge clk_i);
        check_eq("cfg_rdata", 32'(cfg_rdata_o), 32'(model_rdata(cfg_addr_i)));
        @(posedge clk_i);
        model_edge();
        #1;
        check_eq("m_ext_intr", 32'(m_ext_intr_o), 32'(posted));
        check_eq("busy", 32'(busy_o), 32'(posted || in_service));
        check_eq("mcause", 32'(mcause_o), 32'(cause));
        check_eq("claim_id", 32'(claim_id_o), 32'(served_id));
    endtask

    task automatic idle_inputs();
        cfg_wr_i = 0; p_int_read_i = 0; complete_i = 0;
    endtask

    task automatic cfg_write(input logic [4:0] a, input logic [15:0] d);
        cfg_wr_i = 1; cfg_addr_i = a; cfg_wdata_i = d;
        cyc();
        cfg_wr_i = 0;
    endtask

    task automatic randomize_inputs(input bit force_claim);
        logic [NS-1:0] flip;
        int r;
        for (int i = 0; i < NS; i++) flip[i] = ($urandom_range(0, 15) == 0);
        src_i = src_i ^ flip;
        cfg_wr_i = ($urandom_range(0, 7) == 0) && !force_claim;
        r = $urandom_range(0, 11);
        cfg_addr_i  = (r < NS) ? 5'(r) : (r == 8) ? 5'h10 : (r == 9) ? 5'h11 : (r == 10) ? 5'h12 : 5'h1F;
        cfg_wdata_i = 16'($urandom);
        if (r == 9) cfg_wdata_i = 16'($urandom_range(0, 3));
        p_int_read_i = force_claim || ($urandom_range(0, 3) == 0);
        complete_i   = !force_claim && ($urandom_range(0, 5) == 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_i = 1; src_i = '0; cfg_addr_i = '0; cfg_wdata_i = '0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check_eq("rst_m_ext", 32'(m_ext_intr_o), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_mcause", 32'(mcause_o), 32'd0);
        check_eq("rst_claim_id", 32'(claim_id_o), 32'd0);
        rst_i = 0;

        // Single source walk-through.
        cfg_write(5'd2, 16'd3);
        cfg_write(5'h10, 16'h0004);
        src_i[2] = 1'b1;
        cyc();
        cyc();
        check_eq("single_req", 32'(m_ext_intr_o), 32'd1);
        check_eq("single_cause", 32'(mcause_o), 32'd18);
        p_int_read_i = 1;
        cyc();
        p_int_read_i = 0;
        check_eq("single_claim_m_ext", 32'(m_ext_intr_o), 32'd0);
        check_eq("single_claim_id", 32'(claim_id_o), 32'd2);
        check_eq("single_claim_busy", 32'(busy_o), 32'd1);
        complete_i = 1;
        src_i[2] = 1'b0;
        cyc();
        complete_i = 0;
        check_eq("single_done_busy", 32'(busy_o), 32'd0);
        cyc();

        for (int k = 0; k < 4000; k++) begin
            randomize_inputs(1'b0);
            cyc();
        end

        // Drive into SERVICE, then assert reset between clock edges.
        idle_inputs();
        cfg_write(5'd0, 16'd7);
        cfg_write(5'h10, 16'h00FF);
        cfg_write(5'h11, 16'd0);
        n = 0;
        while (!in_service && n < 300) begin
            randomize_inputs(1'b1);
            cyc();
            n++;
        end
        check_eq("reach_service", 32'(in_service), 32'd1);
        idle_inputs();
        cfg_addr_i = 5'h10;
        @(posedge clk_i);
        #3;
        rst_i = 1;
        #1;
        model_reset();
        check_eq("async_m_ext", 32'(m_ext_intr_o), 32'd0);
        check_eq("async_busy", 32'(busy_o), 32'd0);
        check_eq("async_mcause", 32'(mcause_o), 32'd0);
        check_eq("async_claim_id", 32'(claim_id_o), 32'd0);
        check_eq("async_enable_rd", 32'(cfg_rdata_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 0;
        src_i = '0;
        repeat (3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
